adpcm_mc_encoder: RTL and testbench

Multi-channel, parametrised IMA-ADPCM encoder. It is the successor to the single-channel compressor back end: it accepts PCM samples from one or more decimators over a valid/ready handshake and keeps independent predictor and step-index state per channel. It emits one 4-bit code per sample, together with the reconstructed predictor value. It sits between the per-channel CIC decimators and the output serialiser / pin mux.

---
 rtl/adpcm_mc_encoder_if.sv | 26 ++
 rtl/adpcm_mc_encoder.sv | 221 ++++++++++++++++++++++
 tb/tb_adpcm_mc_encoder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/adpcm_mc_encoder_if.sv
// Handshake bundle for adpcm_mc_encoder: PCM sample input and IMA code output streams.
// The slave modport is the encoder's view; master is the producer/consumer side.
interface adpcm_mc_encoder_if #(
  parameter int PCM_W = 16,
  parameter int CH_W  = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [PCM_W-1:0] in_pcm;
  logic [CH_W-1:0]         in_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic [3:0]              out_code;
  logic [CH_W-1:0]         out_ch;
  logic signed [15:0]      out_pred;

  modport master (
    output in_valid, in_pcm, in_ch, out_ready,
    input  in_ready, out_valid, out_code, out_ch, out_pred
  );

  modport slave (
    input  in_valid, in_pcm, in_ch, out_ready,
    output in_ready, out_valid, out_code, out_ch, out_pred
  );
endinterface

// File: rtl/adpcm_mc_encoder.sv
// Multi-channel IMA-ADPCM encoder with per-channel predictor/step-index state.
// Define ADPCM_MC_CLAMP_EN to saturate the predictor instead of wrapping it modulo 2^16.
module adpcm_mc_encoder #(
  parameter int CHANNELS = 2,
  parameter int PCM_W    = 16
) (
  input logic               clk,
  input logic               rst,
  input logic               clear,
  adpcm_mc_encoder_if.slave bus
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(CHANNELS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIFF, S_B2, S_B1, S_B0, S_UPD, S_OUT} state_t;

  function automatic logic [15:0] step_rom(input logic [6:0] i);
    case (i)
      7'd0:  step_rom = 16'd7;     7'd1:  step_rom = 16'd8;     7'd2:  step_rom = 16'd9;     7'd3:  step_rom = 16'd10;
      7'd4:  step_rom = 16'd11;    7'd5:  step_rom = 16'd12;    7'd6:  step_rom = 16'd13;    7'd7:  step_rom = 16'd14;
      7'd8:  step_rom = 16'd16;    7'd9:  step_rom = 16'd17;    7'd10: step_rom = 16'd19;    7'd11: step_rom = 16'd21;
      7'd12: step_rom = 16'd23;    7'd13: step_rom = 16'd25;    7'd14: step_rom = 16'd28;    7'd15: step_rom = 16'd31;
      7'd16: step_rom = 16'd34;    7'd17: step_rom = 16'd37;    7'd18: step_rom = 16'd41;    7'd19: step_rom = 16'd45;
      7'd20: step_rom = 16'd50;    7'd21: step_rom = 16'd55;    7'd22: step_rom = 16'd60;    7'd23: step_rom = 16'd66;
      7'd24: step_rom = 16'd73;    7'd25: step_rom = 16'd80;    7'd26: step_rom = 16'd88;    7'd27: step_rom = 16'd97;
      7'd28: step_rom = 16'd107;   7'd29: step_rom = 16'd118;   7'd30: step_rom = 16'd130;   7'd31: step_rom = 16'd143;
      7'd32: step_rom = 16'd157;   7'd33: step_rom = 16'd173;   7'd34: step_rom = 16'd190;   7'd35: step_rom = 16'd209;
      7'd36: step_rom = 16'd230;   7'd37: step_rom = 16'd253;   7'd38: step_rom = 16'd279;   7'd39: step_rom = 16'd307;
      7'd40: step_rom = 16'd337;   7'd41: step_rom = 16'd371;   7'd42: step_rom = 16'd408;   7'd43: step_rom = 16'd449;
      7'd44: step_rom = 16'd494;   7'd45: step_rom = 16'd544;   7'd46: step_rom = 16'd598;   7'd47: step_rom = 16'd658;
      7'd48: step_rom = 16'd724;   7'd49: step_rom = 16'd796;   7'd50: step_rom = 16'd876;   7'd51: step_rom = 16'd963;
      7'd52: step_rom = 16'd1060;  7'd53: step_rom = 16'd1166;  7'd54: step_rom = 16'd1282;  7'd55: step_rom = 16'd1411;
      7'd56: step_rom = 16'd1552;  7'd57: step_rom = 16'd1707;  7'd58: step_rom = 16'd1878;  7'd59: step_rom = 16'd2066;
      7'd60: step_rom = 16'd2272;  7'd61: step_rom = 16'd2499;  7'd62: step_rom = 16'd2749;  7'd63: step_rom = 16'd3024;
      7'd64: step_rom = 16'd3327;  7'd65: step_rom = 16'd3660;  7'd66: step_rom = 16'd4026;  7'd67: step_rom = 16'd4428;
      7'd68: step_rom = 16'd4871;  7'd69: step_rom = 16'd5358;  7'd70: step_rom = 16'd5894;  7'd71: step_rom = 16'd6484;
      7'd72: step_rom = 16'd7132;  7'd73: step_rom = 16'd7845;  7'd74: step_rom = 16'd8630;  7'd75: step_rom = 16'd9493;
      7'd76: step_rom = 16'd10442; 7'd77: step_rom = 16'd11487; 7'd78: step_rom = 16'd12635; 7'd79: step_rom = 16'd13899;
      7'd80: step_rom = 16'd15289; 7'd81: step_rom = 16'd16818; 7'd82: step_rom = 16'd18500; 7'd83: step_rom = 16'd20350;
      7'd84: step_rom = 16'd22385; 7'd85: step_rom = 16'd24623; 7'd86: step_rom = 16'd27086; 7'd87: step_rom = 16'd29794;
      default: step_rom = 16'd32767;
    endcase
  endfunction

  function automatic logic signed [4:0] idx_adj(input logic [2:0] m);
    case (m)
      3'd4:    idx_adj = 5'sd2;
      3'd5:    idx_adj = 5'sd4;
      3'd6:    idx_adj = 5'sd6;
      3'd7:    idx_adj = 5'sd8;
      default: idx_adj = -5'sd1;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic signed [15:0]    sample_q, sample_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic signed [15:0]    pred_rd_q, pred_rd_d;
  logic [6:0]            idx_rd_q, idx_rd_d;
  logic [16:0]           mag_q, mag_d;
  logic                  sign_q, sign_d;
  logic [15:0]           step_q, step_d;
  logic [16:0]           vp_q, vp_d;
  logic [2:0]            code_q, code_d;
  logic [3:0]            out_code_q;
  logic [CH_W-1:0]       out_ch_q;
  logic signed [15:0]    out_pred_q;

  logic signed [15:0]    pcm16;
  logic signed [15:0]    pred_arr [CHANNELS];
  logic [6:0]            idx_arr  [CHANNELS];
  logic                  wr_en;
  logic signed [15:0]    pred_new;
  logic [6:0]            idx_new;
  logic [15:0]           step_lk;
  logic signed [16:0]    diff;
  logic [15:0]           s;
  logic [1:0]            bpos;
  logic signed [17:0]    sum;
  logic signed [8:0]     isum;

  // Narrow samples are left-aligned, wide ones keep their top 16 bits.
  generate
    if (PCM_W >= 16) begin : g_pcm_trunc
      assign pcm16 = bus.in_pcm[PCM_W-1 -: 16];
    end else begin : g_pcm_shift
      assign pcm16 = {bus.in_pcm, {(16-PCM_W){1'b0}}};
    end
  endgenerate

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [15:0] pred_r;
      logic [6:0]         idx_r;
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          pred_r <= '0;
          idx_r  <= '0;
        end else if (wr_en && ch_q == CH_W'(gi)) begin
          pred_r <= pred_new;
          idx_r  <= idx_new;
        end
      end
      assign pred_arr[gi] = pred_r;
      assign idx_arr[gi]  = idx_r;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) state_q <= S_IDLE;
    else              state_q <= state_d;
    sample_q  <= sample_d;
    ch_q      <= ch_d;
    pred_rd_q <= pred_rd_d;
    idx_rd_q  <= idx_rd_d;
    mag_q     <= mag_d;
    sign_q    <= sign_d;
    step_q    <= step_d;
    vp_q      <= vp_d;
    code_q    <= code_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_code_q <= '0;
      out_ch_q   <= '0;
      out_pred_q <= '0;
    end else if (wr_en && !clear) begin
      out_code_q <= {sign_q, code_q};
      out_ch_q   <= ch_q;
      out_pred_q <= pred_new;
    end
  end

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    ch_d      = ch_q;
    pred_rd_d = pred_rd_q;
    idx_rd_d  = idx_rd_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    step_d    = step_q;
    vp_d      = vp_q;
    code_d    = code_q;
    wr_en     = 1'b0;
    step_lk   = step_rom(idx_rd_q);
    diff      = 17'(sample_q) - 17'(pred_rd_q);
    s         = '0;
    bpos      = '0;
    sum       = '0;
    isum      = '0;
    pred_new  = pred_rd_q;
    idx_new   = idx_rd_q;
    case (state_q)
      S_IDLE: begin
        // Out-of-range channel tags are accepted and dropped without leaving IDLE.
        if (bus.in_valid) begin
          sample_d = pcm16;
          ch_d     = bus.in_ch;
          if ({1'b0, bus.in_ch} < CH_LIM) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        pred_rd_d = pred_arr[ch_q];
        idx_rd_d  = idx_arr[ch_q];
        state_d   = S_DIFF;
      end
      S_DIFF: begin
        sign_d  = diff[16];
        mag_d   = diff[16] ? 17'(-diff) : 17'(diff);
        step_d  = step_lk;
        vp_d    = 17'(step_lk >> 3);
        code_d  = '0;
        state_d = S_B2;
      end
      S_B2, S_B1, S_B0: begin
        if (state_q == S_B2) begin
          s = step_q;      bpos = 2'd2; state_d = S_B1;
        end else if (state_q == S_B1) begin
          s = step_q >> 1; bpos = 2'd1; state_d = S_B0;
        end else begin
          s = step_q >> 2; bpos = 2'd0; state_d = S_UPD;
        end
        if (mag_q >= {1'b0, s}) begin
          code_d[bpos] = 1'b1;
          mag_d        = mag_q - {1'b0, s};
          vp_d         = vp_q + {1'b0, s};
        end
      end
      S_UPD: begin
        sum = sign_q ? (18'(pred_rd_q) - $signed({1'b0, vp_q}))
                     : (18'(pred_rd_q) + $signed({1'b0, vp_q}));
`ifdef ADPCM_MC_CLAMP_EN
        if (sum > 18'sd32767)       pred_new = 16'sh7FFF;
        else if (sum < -18'sd32768) pred_new = 16'sh8000;
        else                        pred_new = sum[15:0];
`else
        pred_new = sum[15:0];
`endif
        isum = $signed({2'b00, idx_rd_q}) + 9'(idx_adj(code_q));
        if (isum < 0)             idx_new = 7'd0;
        else if (isum > 9'sd88)   idx_new = 7'd88;
        else                      idx_new = isum[6:0];
        wr_en   = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_OUT);
  assign bus.out_code  = out_code_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_pred  = out_pred_q;
endmodule

// File: tb/tb_adpcm_mc_encoder.sv
// Directed bench for adpcm_mc_encoder: vector table plus clear, backpressure,
// invalid-channel and predictor-saturation sequences.
module tb_adpcm_mc_encoder;
  localparam int CHN = 3;
  localparam int CHW = 2;

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  adpcm_mc_encoder_if #(.PCM_W(16), .CH_W(CHW)) bus ();

  adpcm_mc_encoder #(.CHANNELS(CHN), .PCM_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit do_rst;
    int ch;
    int pcm;
    int code;
    int pred;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_code", int'(bus.out_code), 0);
    chk("rst_out_ch", int'(bus.out_ch), 0);
    chk("rst_out_pred", int'(bus.out_pred), 0);
  endtask

  // Accept one sample, wait (bounded) for its code, capture it, let it transfer.
  task automatic send(input int ch, input int pcm, output int code, output int pred,
                      output int och, output int lat);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    bus.in_valid = 1'b1;
    bus.in_ch    = ch[CHW-1:0];
    bus.in_pcm   = pcm[15:0];
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    code = int'(bus.out_code);
    pred = int'(bus.out_pred);
    och  = int'(bus.out_ch);
    tick();
  endtask

  initial begin
    int code, pred, och, lat, cnt, bad, prev;
    bit nondec, anyneg;
    logic [3:0] h_code;
    logic signed [15:0] h_pred;
    logic [CHW-1:0] h_ch;

    vecs[0]  = '{1'b1, 0, 0,     0,  0};
    vecs[1]  = '{1'b0, 0, 0,     0,  0};
    vecs[2]  = '{1'b1, 0, 1000,  7,  11};
    vecs[3]  = '{1'b0, 1, 1000,  7,  11};
    vecs[4]  = '{1'b0, 0, 1000,  7,  41};
    vecs[5]  = '{1'b1, 0, -1000, 15, -11};
    vecs[6]  = '{1'b0, 1, -1000, 15, -11};
    vecs[7]  = '{1'b0, 0, -1000, 15, -41};
    vecs[8]  = '{1'b0, 0, 0,     4,  -3};
    vecs[9]  = '{1'b0, 0, -3,    0,  2};
    vecs[10] = '{1'b0, 2, 500,   7,  11};

    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.in_pcm = '0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_rst) do_reset();
      send(vecs[i].ch, vecs[i].pcm, code, pred, och, lat);
      $display("vec %0d ch=%0d pcm=%0d -> code=%0h pred=%0d lat=%0d", i, vecs[i].ch, vecs[i].pcm, code, pred, lat);
      chk($sformatf("v%0d_latency", i), lat, 6);
      chk($sformatf("v%0d_code", i), code, vecs[i].code);
      chk($sformatf("v%0d_pred", i), pred, vecs[i].pred);
      chk($sformatf("v%0d_ch", i), och, vecs[i].ch);
    end

    // Tag 3 is out of range: consumed, no output, no state change on any channel.
    bus.in_valid = 1'b1;
    bus.in_ch = 2'd3;
    bus.in_pcm = 16'sd1000;
    tick();
    bus.in_valid = 1'b0;
    chk("badch_in_ready", int'(bus.in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    chk("badch_no_output", cnt, 0);
    send(0, 2, code, pred, och, lat);
    $display("badch follow-up ch=0 -> code=%0h pred=%0d", code, pred);
    chk("badch_follow_code", code, 0);
    chk("badch_follow_pred", pred, 6);

    // Clear in B1 of a ch1 sample drops it and zeroes every channel.
    bus.in_valid = 1'b1;
    bus.in_ch = 2'd1;
    bus.in_pcm = 16'sd1000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_in_ready", int'(bus.in_ready), 1);
    chk("clear_out_valid", int'(bus.out_valid), 0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    chk("clear_no_output", cnt, 0);
    send(1, 1000, code, pred, och, lat);
    $display("after clear ch=1 -> code=%0h pred=%0d", code, pred);
    chk("clear_ch1_code", code, 7);
    chk("clear_ch1_pred", pred, 11);
    send(0, 1000, code, pred, och, lat);
    $display("after clear ch=0 -> code=%0h pred=%0d", code, pred);
    chk("clear_ch0_pred", pred, 11);

    // Backpressure on ch2 (cleared, so 1000 gives code 7, pred 11).
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_ch = 2'd2;
    bus.in_pcm = 16'sd1000;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    chk("bp_latency", lat, 6);
    h_code = bus.out_code;
    h_pred = bus.out_pred;
    h_ch = bus.out_ch;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!bus.out_valid || bus.in_ready || bus.out_code != h_code ||
          bus.out_pred != h_pred || bus.out_ch != h_ch) bad++;
    end
    $display("backpressure hold code=%0h pred=%0d ch=%0d unstable_cycles=%0d", h_code, h_pred, h_ch, bad);
    chk("bp_hold_stable", bad, 0);
    chk("bp_code", int'(h_code), 7);
    chk("bp_pred", int'(h_pred), 11);
    chk("bp_ch", int'(h_ch), 2);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_release_out_valid", int'(bus.out_valid), 0);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    chk("bp_single_transfer", cnt, 0);

    // Full-scale input drives the predictor to the top of its range.
    do_reset();
    nondec = 1'b1;
    anyneg = 1'b0;
    prev = -40000;
    for (int i = 0; i < 200; i++) begin
      send(0, 32767, code, pred, och, lat);
      if (i < 3) $display("sat %0d -> code=%0h pred=%0d", i, code, pred);
      if (i == 0) chk("sat_pred0", pred, 11);
      if (i == 1) chk("sat_pred1", pred, 41);
      if (i == 2) chk("sat_pred2", pred, 104);
      if (pred < prev) nondec = 1'b0;
      if (pred < 0) anyneg = 1'b1;
      prev = pred;
    end
    $display("sat done last_pred=%0d nondecreasing=%0d wrapped=%0d", pred, nondec, anyneg);
`ifdef ADPCM_MC_CLAMP_EN
    chk("sat_nondecreasing", int'(nondec), 1);
    chk("sat_final_pred", pred, 32767);
`else
    chk("sat_wraps_negative", int'(anyneg), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
